pcileech_mux_sched: RTL and testbench

Burst scheduler between the 256-bit output of the PCILeech word mux and the FT601 transmit FIFO. It owns the mux read enable and opens bounded read bursts only when the downstream FIFO has guaranteed room. Between bursts it enforces a minimum gap, and it can optionally discard words that carry only idle fill. It also keeps transfer statistics for the status path.

---
 rtl/pcileech_mux_sched.sv | 123 ++++++++++++
 tb/tb_pcileech_mux_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_mux_sched.sv
// pcileech_mux_sched
//   Burst scheduler between the 256-bit PCILeech word mux and the FT601 TX FIFO.
//   It opens bounded read bursts toward the mux only while the FIFO has
//   guaranteed room. It forces a minimum gap between bursts, can optionally
//   discard idle-fill words, and keeps transfer statistics.
// Ports
//   clk, rst_n        clock, async active-low reset
//   enable            scheduler enable, sampled each cycle
//   mux_dout/_valid   mux word and its valid (valid only while mux_rd_en)
//   mux_rd_en         registered read enable to the mux
//   fifo_din/_wr_en   TX FIFO write port (zero latency from the mux)
//   fifo_space        FIFO free entries (may lag one cycle)
//   burst_done        one-cycle pulse when BURST is left
//   stat_words        words written to the FIFO (wraps)
//   stat_idle_drop    idle words dropped (saturates)
module pcileech_mux_sched #(
  parameter int BURST_MAX  = 16,
  parameter int SPACE_W    = 10,
  parameter int SPACE_MIN  = 3,
  parameter int GAP_CYCLES = 4,
  parameter int IDLE_TO    = 32,
  parameter bit DROP_IDLE  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [255:0]       mux_dout,
  input  logic               mux_valid,
  output logic               mux_rd_en,
  output logic [255:0]       fifo_din,
  output logic               fifo_wr_en,
  input  logic [SPACE_W-1:0] fifo_space,
  output logic               burst_done,
  output logic [31:0]        stat_words,
  output logic [15:0]        stat_idle_drop
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] BEAT_LAST = 8'(BURST_MAX - 1);
  localparam logic [7:0] NV_LAST   = 8'(IDLE_TO - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] beat, beat_n;
  logic [7:0] nv, nv_n;
  logic [3:0] gap, gap_n;

  logic space_ok, all_idle, drop, burst_exit;

  // Idle fill: seven context nibbles F, marker nibble E.
  assign all_idle   = (mux_dout[255:224] == 32'hFFFF_FFEF);
  assign drop       = DROP_IDLE && all_idle;
  assign space_ok   = (fifo_space >= SPACE_W'(SPACE_MIN));
  assign fifo_din   = mux_dout;
  assign fifo_wr_en = mux_valid && !drop;

  // All exit causes fold into one term so simultaneous causes give one exit.
  assign burst_exit = (mux_valid && beat == BEAT_LAST) || !space_ok || !enable ||
                      (!mux_valid && nv == NV_LAST);

  always_comb begin
    state_n = state;
    beat_n  = beat;
    nv_n    = nv;
    gap_n   = gap;
    case (state)
      S_IDLE: begin
        if (enable && space_ok) begin
          state_n = S_BURST;
          beat_n  = '0;
          nv_n    = '0;
        end
      end
      S_BURST: begin
        if (mux_valid) begin
          beat_n = beat + 8'd1;
          nv_n   = '0;
        end else begin
          nv_n = nv + 8'd1;
        end
        if (burst_exit) begin
          state_n = S_GAP;
          gap_n   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap == '0) state_n = S_IDLE;
        else           gap_n   = gap - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      beat           <= '0;
      nv             <= '0;
      gap            <= '0;
      mux_rd_en      <= 1'b0;
      burst_done     <= 1'b0;
      stat_words     <= '0;
      stat_idle_drop <= '0;
    end else begin
      state      <= state_n;
      beat       <= beat_n;
      nv         <= nv_n;
      gap        <= gap_n;
      // Registered from next state so rd_en tracks BURST cycle-exactly.
      mux_rd_en  <= (state_n == S_BURST);
      burst_done <= (state == S_BURST) && (state_n != S_BURST);
      if (fifo_wr_en) stat_words <= stat_words + 32'd1;
      if (mux_valid && drop && stat_idle_drop != 16'hFFFF)
        stat_idle_drop <= stat_idle_drop + 16'd1;
    end
  end

endmodule

// File: tb/tb_pcileech_mux_sched.sv
// Directed bench for pcileech_mux_sched: three instances (default params,
// DROP_IDLE=0, and a long-burst instance used to reach drop-counter saturation).
module tb_pcileech_mux_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for the default and no-drop instances
  logic         en = 1'b0;
  logic         supply = 1'b0;
  logic [255:0] dout = '0;
  logic [9:0]   space = 10'd100;

  logic         rd_m, wr_m, done_m, valid_m;
  logic [255:0] din_m;
  logic [31:0]  words_m;
  logic [15:0]  drops_m;

  logic         rd_n, wr_n, done_n, valid_n;
  logic [255:0] din_n;
  logic [31:0]  words_n;
  logic [15:0]  drops_n;

  logic         en_s = 1'b0;
  logic         rd_s, wr_s, done_s, valid_s;
  logic [255:0] din_s;
  logic [255:0] dout_s = {32'hFFFF_FFEF, 224'h0};
  logic [31:0]  words_s;
  logic [15:0]  drops_s;

  // mux model: valid only while read enable is high
  assign valid_m = rd_m & supply;
  assign valid_n = rd_n & supply;
  assign valid_s = rd_s;

  pcileech_mux_sched dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .mux_dout(dout), .mux_valid(valid_m),
    .mux_rd_en(rd_m), .fifo_din(din_m), .fifo_wr_en(wr_m), .fifo_space(space),
    .burst_done(done_m), .stat_words(words_m), .stat_idle_drop(drops_m));

  pcileech_mux_sched #(.DROP_IDLE(1'b0)) dut_nd (
    .clk(clk), .rst_n(rst_n), .enable(en), .mux_dout(dout), .mux_valid(valid_n),
    .mux_rd_en(rd_n), .fifo_din(din_n), .fifo_wr_en(wr_n), .fifo_space(space),
    .burst_done(done_n), .stat_words(words_n), .stat_idle_drop(drops_n));

  pcileech_mux_sched #(.BURST_MAX(255), .GAP_CYCLES(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(en_s), .mux_dout(dout_s), .mux_valid(valid_s),
    .mux_rd_en(rd_s), .fifo_din(din_s), .fifo_wr_en(wr_s), .fifo_space(10'd100),
    .burst_done(done_s), .stat_words(words_s), .stat_idle_drop(drops_s));

  // event counters, only written here
  int wr_cnt = 0, done_cnt = 0, hi_cnt = 0;
  always @(posedge clk) begin
    if (wr_m)   wr_cnt   <= wr_cnt + 1;
    if (done_m) done_cnt <= done_cnt + 1;
    if (rd_m)   hi_cnt   <= hi_cnt + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_rd(input logic lvl, input string nm);
    int k = 0;
    while (rd_m !== lvl && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(rd_m), 32'(lvl));
  endtask

  // count negedges at which rd_m equals lvl, stop at first other value
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (rd_m === lvl && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0; supply = 1'b0; space = 10'd100; en_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] status;
    logic        sup;
    logic        exp_m;
    logic        exp_n;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int n, w0, d0, h0;
    tbl[0]  = '{32'hFFFF_FFEF, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{32'h0F0F_0FE0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{32'hFFFF_FFEF, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{32'h0F0F_0FE0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{32'hFFFF_FFEF, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{32'hFFFF_FFEF, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{32'h0F0F_0FE0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{32'hFFFF_FFEF, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{32'h0F0F_0FE0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{32'hFFFF_FFEE, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{32'h7FFF_FFEF, 1'b1, 1'b1, 1'b1};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_rd_en", 32'(rd_m), 0);
    check("rst_done", 32'(done_m), 0);
    check("rst_words", words_m, 0);
    check("rst_drops", 32'(drops_m), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // full burst, twice
    dout = {32'h1234_5670, 224'h0};
    supply = 1'b1; en = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    wait_rd(1'b1, "full_rise1");
    run_len(1'b1, n);
    check("full_high1", n, 16);
    check("full_writes1", wr_cnt - w0, 16);
    check("full_done1", 32'(done_m), 1);
    run_len(1'b0, n);
    check("full_gap", n, 5);
    run_len(1'b1, n);
    check("full_high2", n, 16);
    check("full_words2", words_m, 32);
    check("full_done2", 32'(done_m), 1);
    @(negedge clk);
    check("full_done_pulse", 32'(done_m), 0);
    check("full_done_cnt", done_cnt - d0, 2);

    // space throttle
    do_reset();
    space = 10'd10; supply = 1'b1; en = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    wait_rd(1'b1, "thr_rise");
    n = 0;
    while (wr_cnt - w0 < 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    space = 10'd2;
    @(negedge clk);
    check("thr_rd_fall", 32'(rd_m), 0);
    h0 = hi_cnt;
    repeat (40) @(negedge clk);
    check("thr_writes", wr_cnt - w0, 6);
    check("thr_no_burst", hi_cnt - h0, 0);
    check("thr_done_cnt", done_cnt - d0, 1);
    space = 10'd10;
    wait_rd(1'b1, "thr_resume");

    // idle drop, table driven on both drop settings
    do_reset();
    supply = 1'b0; en = 1'b1;
    wait_rd(1'b1, "drop_rise");
    for (int i = 0; i < 11; i++) begin
      dout = {tbl[i].status, 224'(i * 32'h0101_0101)};
      supply = tbl[i].sup;
      #1;
      check($sformatf("drop_wr_m[%0d]", i), 32'(wr_m), 32'(tbl[i].exp_m));
      check($sformatf("drop_wr_n[%0d]", i), 32'(wr_n), 32'(tbl[i].exp_n));
      check($sformatf("drop_din[%0d]", i), din_m[255:224], tbl[i].status);
      @(negedge clk);
    end
    supply = 1'b0; en = 1'b0;
    @(negedge clk);
    check("drop_words_m", words_m, 6);
    check("drop_drops_m", 32'(drops_m), 4);
    check("drop_words_n", words_n, 10);
    check("drop_drops_n", 32'(drops_n), 0);

    // idle timeout
    do_reset();
    supply = 1'b0; en = 1'b1;
    wait_rd(1'b1, "to_rise");
    run_len(1'b1, n);
    check("to_high", n, 32);
    check("to_done", 32'(done_m), 1);
    check("to_words", words_m, 0);

    // enable drop mid-burst
    do_reset();
    supply = 1'b1; en = 1'b1;
    wait_rd(1'b1, "en_rise");
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_rd_fall", 32'(rd_m), 0);
    check("en_done", 32'(done_m), 1);
    h0 = hi_cnt;
    repeat (30) @(negedge clk);
    check("en_stay_idle", hi_cnt - h0, 0);

    // reset mid-burst
    en = 1'b1;
    wait_rd(1'b1, "rst_rise");
    repeat (2) @(negedge clk);
    check("rst_pre_words", 32'(words_m != 0), 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_rd_en", 32'(rd_m), 0);
    check("rstmid_wr_en", 32'(wr_m), 0);
    check("rstmid_words", words_m, 0);
    check("rstmid_drops", 32'(drops_m), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    @(negedge clk);

    // drop counter saturation (long bursts of idle words)
    en_s = 1'b1;
    n = 0;
    while (drops_s !== 16'hFFFF && n < 80000) begin
      @(negedge clk);
      n++;
    end
    check("sat_reach", 32'(drops_s), 32'h0000_FFFF);
    repeat (300) @(negedge clk);
    check("sat_hold", 32'(drops_s), 32'h0000_FFFF);
    check("sat_words", words_s, 0);
    en_s = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
